// File: rtl/jt89_noise_if.sv
// Register-file side of the noise channel: enables, control write, volume, tone2 tap and sample out.
// Sample is registered in the generator, one clk_en after inputs; no backpressure.
interface jt89_noise_if #(
   parameter int bw = 9
);
   logic          clk_en;
   logic          cen_16;
   logic          wr;
   logic [2:0]    din;
   logic [3:0]    vol;
   logic          tone2;
   logic [bw-1:0] noise;

   modport master (output clk_en, cen_16, wr, din, vol, tone2, input noise);
   modport slave  (input clk_en, cen_16, wr, din, vol, tone2, output noise);
endinterface

// File: rtl/jt89_noise.sv
// SN76489 noise channel: rate counter or tone2 clocks an LFSR, bit 0 gated by vol; 1 clk_en latency, no backpressure.
// Define JT89_SMS_LFSR_EN for the 16-bit Sega VDP LFSR (taps 0,3); otherwise the 15-bit TI LFSR (taps 0,1).
module jt89_noise #(
   parameter int bw = 9
) (
   input  logic        clk,
   input  logic        rst,
   jt89_noise_if.slave nif
);
`ifdef JT89_SMS_LFSR_EN
   localparam int W   = 16;
   localparam int TAP = 3;
`else
   localparam int W   = 15;
   localparam int TAP = 1;
`endif
   localparam logic [W-1:0] SEED = {1'b1, {(W-1){1'b0}}};

   logic [2:0]    ctrl_q, ctrl_d;
   logic [9:0]    cnt_q, cnt_d;
   logic          nff_q, nff_d;
   logic          nff_last_q, nff_last_d;
   logic [W-1:0]  lfsr_q, lfsr_d;
   logic [bw-1:0] noise_q, noise_d;
   logic [bw-1:0] amp_w;
   logic          fb;
   logic          tone_mode;

   function automatic logic [9:0] reload(input logic [1:0] rate);
      case (rate)
         2'd1:    reload = 10'h20;
         2'd2:    reload = 10'h40;
         default: reload = 10'h10;
      endcase
   endfunction

   function automatic logic [7:0] amp(input logic [3:0] v);
      case (v)
         4'd0:    amp = 8'd255;
         4'd1:    amp = 8'd203;
         4'd2:    amp = 8'd161;
         4'd3:    amp = 8'd128;
         4'd4:    amp = 8'd102;
         4'd5:    amp = 8'd81;
         4'd6:    amp = 8'd64;
         4'd7:    amp = 8'd51;
         4'd8:    amp = 8'd40;
         4'd9:    amp = 8'd32;
         4'd10:   amp = 8'd26;
         4'd11:   amp = 8'd20;
         4'd12:   amp = 8'd16;
         4'd13:   amp = 8'd13;
         4'd14:   amp = 8'd10;
         default: amp = 8'd0;
      endcase
   endfunction

   assign amp_w     = bw'(amp(nif.vol)) << (bw - 9);
   assign fb        = ctrl_q[2] ? (lfsr_q[0] ^ lfsr_q[TAP]) : lfsr_q[0];
   assign tone_mode = (ctrl_q[1:0] == 2'd3);
   assign nif.noise = noise_q;

   always_comb begin
      ctrl_d     = ctrl_q;
      cnt_d      = cnt_q;
      nff_d      = nff_q;
      nff_last_d = nff_last_q;
      lfsr_d     = lfsr_q;
      noise_d    = noise_q;
      if (nif.clk_en) begin
         noise_d    = lfsr_q[0] ? amp_w : '0;
         nff_last_d = nff_q;
         // nff_last trails nff by one clk_en, so each rising edge shifts exactly once
         if (nff_q && !nff_last_q)
            lfsr_d = {fb, lfsr_q[W-1:1]};
         if (tone_mode)
            nff_d = nif.tone2;
         else if (nif.cen_16) begin
            if (cnt_q > 10'd1)
               cnt_d = cnt_q - 10'd1;
            else begin
               cnt_d = reload(ctrl_q[1:0]);
               nff_d = ~nff_q;
            end
         end
      end
      // A control write restarts the channel and overrides any tick or shift on this edge
      if (nif.wr) begin
         ctrl_d     = nif.din;
         cnt_d      = reload(nif.din[1:0]);
         nff_d      = 1'b0;
         nff_last_d = 1'b0;
         lfsr_d     = SEED;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_q     <= 3'd0;
         cnt_q      <= 10'h10;
         nff_q      <= 1'b0;
         nff_last_q <= 1'b0;
         lfsr_q     <= SEED;
         noise_q    <= '0;
      end else begin
         ctrl_q     <= ctrl_d;
         cnt_q      <= cnt_d;
         nff_q      <= nff_d;
         nff_last_q <= nff_last_d;
         lfsr_q     <= lfsr_d;
         noise_q    <= noise_d;
      end
   end
endmodule

// File: doc/jt89_noise.md
JT89_NOISE -- requirements
Module: jt89_noise

Interface
REQ-001 Parameter bw, default 9, output sample width; bw<9 is unsupported.
REQ-002 rst  input  1  asynchronous active-high reset.
REQ-003 clk  input  1  system clock; all state on its rising edge.
REQ-004 clk_en  input  1  chip clock enable; qualifies all state updates except writes.
REQ-005 cen_16  input  1  divide-by-16 tick; noise counter advances only when clk_en and cen_16 are both 1.
REQ-006 wr  input  1  one-clk noise-control write strobe.
REQ-007 din  input  3  control data: din[2] = FB (1 = white, 0 = periodic), din[1:0] = rate.
REQ-008 vol  input  4  attenuation, 2 dB steps; 0xF = silent.
REQ-009 tone2  input  1  channel-2 tone flip-flop output, used when rate = 3.
REQ-010 noise  output  bw  registered unsigned-amplitude sample feeding the mixer noise input.

Function
REQ-011 Control register ctrl[2:0] SHALL load din on any clk edge with wr=1, independent of clk_en.
REQ-012 Reload value N SHALL be 0x10 (rate 0), 0x20 (rate 1) or 0x40 (rate 2); 10-bit down counter.
REQ-013 On each tick (clk_en & cen_16) with rate≠3: counter >1 -> decrement; counter ≤1 -> reload N and toggle internal flip-flop nff.
REQ-014 With rate = 3, the counter SHALL hold and nff SHALL follow tone2, sampled on every clk_en.
REQ-015 The LFSR SHALL shift exactly once per nff 0->1 transition, detected on clk_en cycles.
REQ-016 Shift: lfsr <= {fb, lfsr[W-1:1]}; white fb = XOR of tap bits; periodic fb = lfsr[0].
REQ-017 Output bit = lfsr[0]; noise SHALL equal amp(vol) when the bit is 1, else 0, registered on clk_en (latency 1 clk_en cycle).
REQ-018 amp table for vol 0..15 = 255,203,161,128,102,81,64,51,40,32,26,20,16,13,10,0, left-shifted by bw-9.
REQ-019 A write SHALL set lfsr to SEED, counter to the new N and nff to 0 on the same edge.
REQ-020 Write coincident with a tick or shift: the write wins, with no shift or decrement that cycle.
REQ-021 Rate changes SHALL take effect at the next counter reload, except through the write reset in REQ-019.
REQ-022 vol changes SHALL be visible at the next clk_en output update without affecting LFSR state.
REQ-023 clk_en=0 SHALL freeze counter, nff, lfsr and noise, except for writes.

Reset
REQ-024 While rst=1, the block SHALL hold: ctrl=0, counter=0x10, nff=0, lfsr=SEED, noise=0.
REQ-025 Reset asserted mid-shift or mid-write SHALL abort the operation, leaving only reset values.
REQ-026 First tick after reset release SHALL decrement from 0x10.

Configuration
REQ-027 Macro JT89_SMS_LFSR_EN defined: W=16, SEED=0x8000, white taps bits 0 and 3 (Sega VDP variant).
REQ-028 Macro undefined: W=15, SEED=0x4000, white taps bits 0 and 1 (TI SN76489 variant).
REQ-029 Periodic mode period SHALL equal W shifts in both builds.

Verification
REQ-030 Reset, vol=0: noise=0, lfsr=SEED; first output 1 occurs only after W-1 shifts in periodic mode.
REQ-031 Write din=3'b000 (periodic, rate 0), clk_en=cen_16=1 continuously: one LFSR shift every 32 ticks; output 255 for 1 of every W shifts.
REQ-032 Write din=3'b100 (white, rate 2), SMS build: first 8 output bits after seed 0x8000 match the golden model; lfsr never reaches 0.
REQ-033 rate=3 with tone2 toggling every 5 clk_en: one shift per tone2 rising edge; counter held.
REQ-034 wr asserted on the same clk as an nff rising edge: lfsr=SEED afterward, with no extra shift.
REQ-035 vol swept 0->15 while bit=1: noise follows the REQ-018 table one clk_en later, with 0 at vol=15.
